encoder_event_arbiter: RTL
==========================

# encoder_event_arbiter

Shares the CPU event interface among several rotary-encoder front ends. Each front end raises a held "state changed" flag with a direction bit. This block grants one requester at a time in round-robin order and acknowledges it through the front end's read strobe. It queues a compact event byte in a small FIFO for the CPU and keeps a saturating 8-bit position counter per channel for volume-style controls.

## Interface
Parameters:
- NUM_ENC, 4, number of encoder channels (1..8)
- FIFO_DEPTH, 8, event FIFO depth (power of 2, 2..16)
- POS_INIT, 0, reset/clear-to value of every position counter (0..255)

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on posedge clk
- enc_change  in  NUM_ENC  per-channel change flag, held high by the front end until acknowledged
- enc_clkwise  in  NUM_ENC  per-channel direction (1 = clockwise), valid while enc_change is high
- enc_ack  out  NUM_ENC  one-cycle acknowledge pulse to the granted front end's read strobe; one-hot or zero
- evt_rd_stb  in  1  CPU pop strobe, one cycle
- evt_valid  out  1  FIFO non-empty; also serves as CPU interrupt level
- evt_data  out  8  FIFO head: [7:5] channel, [4] clockwise, [3] drop flag, [2:0] = 0
- fifo_count  out  5  entries held (0..FIFO_DEPTH)
- pos_clr  in  NUM_ENC  per-channel counter clear, one cycle
- pos_sel  in  3  counter read select
- pos_value  out  8  registered counter of channel pos_sel; 0 if pos_sel >= NUM_ENC

## Operation
- FSM states are IDLE, ACK and RELEASE. Reset state is IDLE.
- IDLE:
  - If any enc_change bit is set, grant the first set bit searching upward from last_grant+1, with wrap-around.
  - Latch the channel and enc_clkwise[ch], then go to ACK.
  - With no requests, stay in IDLE.
- ACK:
  - enc_ack[ch] = 1 for exactly this cycle.
  - Push the event at the end of the cycle.
  - Update pos[ch]: +1 if clockwise, saturating at 255; −1 otherwise, saturating at 0.
  - Set last_grant = ch, then go to RELEASE.
- RELEASE: one fixed cycle that lets the front end drop its flag. Then go to IDLE. Requests are not sampled in this state.
- last_grant resets to NUM_ENC−1, so channel 0 has first priority after reset.
- FIFO push:
  - A push is accepted if fifo_count < FIFO_DEPTH, or if evt_rd_stb pops in the same cycle.
  - If a push is refused, the event is dropped and the sticky drop bit is set. enc_ack and the counter update still occur.
  - The next accepted push carries bit[3] = drop and clears the drop bit in that same cycle.
- FIFO pop:
  - evt_rd_stb with evt_valid = 1 pops at the clock edge; the new head is visible the next cycle.
  - evt_rd_stb while empty is ignored.
  - A simultaneous push and pop leaves fifo_count unchanged.
- Counters:
  - pos_clr[i] sets pos[i] = POS_INIT.
  - If a clear and an update hit the same channel in the same cycle, the clear wins.
  - Clears on other channels are independent.
- pos_value <= pos[pos_sel] every cycle.

## Timing
- Reset values: enc_ack = 0, evt_valid = 0, evt_data = 0, fifo_count = 0, pos_value = POS_INIT, all pos = POS_INIT, drop = 0, FSM in IDLE.
- Reset mid-operation:
  - Any pending ACK is aborted with no pulse.
  - The FIFO is flushed and the counters are reinitialised.
  - Front-end flags remain held and are serviced after reset releases.
- Latency, with request seen in IDLE at cycle 0:
  - cycle 1: enc_ack high.
  - cycle 2: evt_valid high, event at head if the FIFO was empty; pos updated.
  - cycle 3: pos_value reflects the update, if selected.
  - cycle 3: FSM back in IDLE.
- Throughput is one grant per 3 cycles. Each pending channel is serviced within 3·NUM_ENC cycles.
- enc_ack is registered and glitch-free, and is never asserted for two channels at once.

## Test plan
- Single event, ch2 clockwise, FIFO empty:
  - enc_ack = 0b0100 for one cycle at cycle 1.
  - evt_data = 0x50 at cycle 2, with evt_valid = 1.
  - pos[2] goes from 0 to 1.
  - evt_rd_stb clears evt_valid on the next cycle.
- Round-robin:
  - Hold enc_change = 0b1111 continuously with flags re-raised after each ack.
  - Grant order is 0,1,2,3,0,…; no channel is granted twice before all the others.
- Overflow (FIFO_DEPTH = 8):
  - Push 10 events on ch1 without reads.
  - fifo_count saturates at 8; events 9 and 10 are dropped.
  - pos[1] = 10 regardless of the drops.
  - Drain, then one more event: evt_data bit[3] = 1. The following event has bit[3] = 0.
- Saturation: 3 counter-clockwise events on ch0 from 0 give pos_value = 0. 260 clockwise events give 255.
- Clear collision: assert pos_clr[3] in the ACK cycle of a clockwise event on ch3 with pos[3] = 7. The result is pos[3] = POS_INIT.
- Push/pop collision and reset:
  - FIFO full, and a push coincides with evt_rd_stb: fifo_count stays 8 and no drop is flagged.
  - Assert reset during ACK: all outputs return to reset values. After release, the held request is re-granted within 3 cycles.

Source files
------------

// File: rtl/encoder_event_arbiter.sv
// ---------------------------------------------------------------------------
// encoder_event_arbiter
//   Shares one CPU event interface among NUM_ENC rotary-encoder front ends.
//   Pending "changed" flags are granted round-robin. Each grant is
//   acknowledged with a one-cycle enc_ack pulse. A compact event byte is
//   queued in a FIFO, and the channel's saturating 8-bit position counter is
//   stepped.
//
//   Ports
//     clk, reset        : clock, synchronous active-low reset
//     enc_change[]      : per-channel held change flag
//     enc_clkwise[]     : per-channel direction (1 = clockwise)
//     enc_ack[]         : one-cycle acknowledge, one-hot or zero
//     evt_rd_stb        : CPU pop strobe
//     evt_valid         : FIFO non-empty (interrupt level)
//     evt_data          : FIFO head {ch[2:0], cw, drop, 3'b0}, 0 when empty
//     fifo_count        : entries held
//     pos_clr[]         : per-channel counter clear to POS_INIT
//     pos_sel           : counter read select
//     pos_value         : registered counter of pos_sel, 0 if out of range
// ---------------------------------------------------------------------------

// Per-channel saturating position counter; a clear beats a same-cycle step.
module encoder_pos_counter #(
    parameter int POS_INIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       upd,
    input  logic       cw,
    input  logic       clr,
    output logic [7:0] pos
);
    logic [7:0] pos_q, pos_d;

    always_comb begin
        pos_d = pos_q;
        if (clr) begin
            pos_d = 8'(POS_INIT);
        end else if (upd) begin
            if (cw) begin
                if (pos_q != 8'hFF) pos_d = pos_q + 8'd1;
            end else begin
                if (pos_q != 8'h00) pos_d = pos_q - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) pos_q <= 8'(POS_INIT);
        else        pos_q <= pos_d;
    end

    assign pos = pos_q;
endmodule

module encoder_event_arbiter #(
    parameter int NUM_ENC    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int POS_INIT   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_ENC-1:0] enc_change,
    input  logic [NUM_ENC-1:0] enc_clkwise,
    output logic [NUM_ENC-1:0] enc_ack,
    input  logic               evt_rd_stb,
    output logic               evt_valid,
    output logic [7:0]         evt_data,
    output logic [4:0]         fifo_count,
    input  logic [NUM_ENC-1:0] pos_clr,
    input  logic [2:0]         pos_sel,
    output logic [7:0]         pos_value
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_RELEASE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         grant_ch_q, grant_ch_d;
    logic [2:0]         last_q, last_d;
    logic               cw_q, cw_d;
    logic [NUM_ENC-1:0] enc_ack_q, enc_ack_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [7:0]         mem_d [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]         count_q, count_d;
    logic               drop_q, drop_d;
    logic [7:0]         pos_value_q, pos_value_d;

    logic [NUM_ENC-1:0][7:0] pos;
    logic [NUM_ENC-1:0]      pos_upd;

    // Round-robin pick: lowest requester above last_q, else lowest overall.
    logic [2:0] sel_hi, sel_lo, grant_sel;
    logic       found_hi, found_lo, sel_cw;

    always_comb begin
        sel_hi   = '0;
        sel_lo   = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int i = 0; i < NUM_ENC; i++) begin
            if (enc_change[i]) begin
                if (!found_lo) begin
                    found_lo = 1'b1;
                    sel_lo   = 3'(i);
                end
                if (!found_hi && (3'(i) > last_q)) begin
                    found_hi = 1'b1;
                    sel_hi   = 3'(i);
                end
            end
        end
        grant_sel = found_hi ? sel_hi : sel_lo;
        sel_cw    = 1'b0;
        for (int i = 0; i < NUM_ENC; i++) begin
            if (grant_sel == 3'(i)) sel_cw = enc_clkwise[i];
        end
    end

    for (genvar g = 0; g < NUM_ENC; g++) begin : g_pos
        assign pos_upd[g] = (state_q == S_ACK) && (grant_ch_q == 3'(g));
        encoder_pos_counter #(.POS_INIT(POS_INIT)) u_pos (
            .clk   (clk),
            .reset (reset),
            .upd   (pos_upd[g]),
            .cw    (cw_q),
            .clr   (pos_clr[g]),
            .pos   (pos[g])
        );
    end

    logic pop, push, accept;

    always_comb begin
        state_d     = state_q;
        grant_ch_d  = grant_ch_q;
        last_d      = last_q;
        cw_d        = cw_q;
        enc_ack_d   = '0;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        drop_d      = drop_q;
        pos_value_d = '0;

        // The ack pulse is loaded on entry to ACK so that it is a clean flop output.
        unique case (state_q)
            S_IDLE: begin
                if (|enc_change) begin
                    state_d    = S_ACK;
                    grant_ch_d = grant_sel;
                    cw_d       = sel_cw;
                    for (int i = 0; i < NUM_ENC; i++) begin
                        if (grant_sel == 3'(i)) enc_ack_d[i] = 1'b1;
                    end
                end
            end
            S_ACK: begin
                state_d = S_RELEASE;
                last_d  = grant_ch_q;
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // A full FIFO still accepts if the same edge frees a slot.
        pop    = evt_rd_stb && (count_q != 5'd0);
        push   = (state_q == S_ACK);
        accept = push && ((count_q < 5'(FIFO_DEPTH)) || pop);

        if (accept) begin
            mem_d[wr_ptr_q] = {grant_ch_q, cw_q, drop_q, 3'b000};
            wr_ptr_d        = wr_ptr_q + AW'(1);
            drop_d          = 1'b0;
        end else if (push) begin
            drop_d = 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

        unique case ({accept, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase

        for (int i = 0; i < NUM_ENC; i++) begin
            if (pos_sel == 3'(i)) pos_value_d = pos[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            grant_ch_q  <= '0;
            last_q      <= 3'(NUM_ENC - 1);
            cw_q        <= 1'b0;
            enc_ack_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            drop_q      <= 1'b0;
            pos_value_q <= 8'(POS_INIT);
        end else begin
            state_q     <= state_d;
            grant_ch_q  <= grant_ch_d;
            last_q      <= last_d;
            cw_q        <= cw_d;
            enc_ack_q   <= enc_ack_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
            pos_value_q <= pos_value_d;
        end
    end

    assign enc_ack    = enc_ack_q;
    assign evt_valid  = (count_q != 5'd0);
    assign evt_data   = evt_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;
    assign pos_value  = pos_value_q;
endmodule
